// File: rtl/heartbeat_ctrl.sv
// Sequencing controller for heartbeat_counter: warm-up discard, sliding average, brady/tachy
// alarms with hysteresis and no-pulse fault. Define HEARTBEAT_CTRL_STICKY_ALARM_EN for latching alarms.
module heartbeat_ctrl #(
  parameter int unsigned AVG_DEPTH       = 4,
  parameter int unsigned LOW_BPM         = 50,
  parameter int unsigned HIGH_BPM        = 120,
  parameter int unsigned ALARM_WINDOWS   = 2,
  parameter int unsigned TIMEOUT_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] hb_bpm,
  input  logic       hb_new_bpm,
  output logic       hb_reset,
  output logic [7:0] avg_bpm,
  output logic       avg_valid,
  output logic       alarm_low,
  output logic       alarm_high,
  output logic       no_pulse,
  output logic       busy,
  output logic [1:0] state
);

  localparam int unsigned LogDepth = $clog2(AVG_DEPTH);
  localparam int unsigned SumW     = 8 + LogDepth;
  localparam int unsigned AlW      = $clog2(ALARM_WINDOWS + 1);
  localparam int unsigned ZcW      = $clog2(TIMEOUT_WINDOWS + 1);

  localparam logic [AlW-1:0]    AlarmMax = AlW'(ALARM_WINDOWS);
  localparam logic [ZcW-1:0]    ZeroMax  = ZcW'(TIMEOUT_WINDOWS);
  localparam logic [LogDepth:0] FillMax  = (LogDepth + 1)'(AVG_DEPTH);
  localparam logic [7:0]        LowBpm   = 8'(LOW_BPM);
  localparam logic [7:0]        HighBpm  = 8'(HIGH_BPM);

`ifdef HEARTBEAT_CTRL_STICKY_ALARM_EN
  localparam bit StickyAlarm = 1'b1;
`else
  localparam bit StickyAlarm = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StFault  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          samp_q [AVG_DEPTH];
  logic [7:0]          samp_d [AVG_DEPTH];
  logic [LogDepth-1:0] wr_ptr_q, wr_ptr_d;
  logic [LogDepth:0]   fill_q, fill_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [ZcW-1:0]      zero_cnt_q, zero_cnt_d;
  logic [AlW-1:0]      low_cnt_q, low_cnt_d;
  logic [AlW-1:0]      high_cnt_q, high_cnt_d;
  logic [AlW-1:0]      in_cnt_q, in_cnt_d;
  logic                alarm_low_q, alarm_low_d;
  logic                alarm_high_q, alarm_high_d;
  logic [7:0]          avg_bpm_q, avg_bpm_d;
  logic                avg_valid_q, avg_valid_d;
  logic                hb_reset_q, no_pulse_q, busy_q;
  logic                clear, push;

  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    sum_d        = sum_q;
    zero_cnt_d   = zero_cnt_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    in_cnt_d     = in_cnt_q;
    alarm_low_d  = alarm_low_q;
    alarm_high_d = alarm_high_q;
    avg_bpm_d    = avg_bpm_q;
    avg_valid_d  = 1'b0;
    clear        = 1'b0;
    push         = 1'b0;

    if (stop) begin
      state_d = StIdle;
      clear   = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StWarmup;
            clear   = 1'b1;
          end
        end
        StWarmup: begin
          // First result after release is a settling window: drop it.
          if (hb_new_bpm) state_d = StRun;
        end
        StRun: begin
          if (hb_new_bpm) begin
            if (hb_bpm == 8'd0) begin
              zero_cnt_d = zero_cnt_q + 1'b1;
              if (zero_cnt_d >= ZeroMax) state_d = StFault;
            end else begin
              push = 1'b1;
            end
          end
        end
        StFault: begin
          if (start) begin
            state_d = StWarmup;
            clear   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (push) begin
      zero_cnt_d       = '0;
      sum_d            = sum_q - SumW'(samp_q[wr_ptr_q]) + SumW'(hb_bpm);
      samp_d[wr_ptr_q] = hb_bpm;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (fill_q != FillMax) fill_d = fill_q + 1'b1;
      if (fill_d == FillMax) begin
        avg_valid_d = 1'b1;
        avg_bpm_d   = sum_d[LogDepth +: 8];
      end

      if (hb_bpm > HighBpm) begin
        high_cnt_d = (high_cnt_q == AlarmMax) ? high_cnt_q : high_cnt_q + 1'b1;
        low_cnt_d  = '0;
        in_cnt_d   = '0;
        if (high_cnt_d == AlarmMax) begin
          alarm_high_d = 1'b1;
          if (!StickyAlarm) alarm_low_d = 1'b0;
        end
      end else if (hb_bpm < LowBpm) begin
        low_cnt_d  = (low_cnt_q == AlarmMax) ? low_cnt_q : low_cnt_q + 1'b1;
        high_cnt_d = '0;
        in_cnt_d   = '0;
        if (low_cnt_d == AlarmMax) begin
          alarm_low_d = 1'b1;
          if (!StickyAlarm) alarm_high_d = 1'b0;
        end
      end else begin
        low_cnt_d  = '0;
        high_cnt_d = '0;
        in_cnt_d   = (in_cnt_q == AlarmMax) ? in_cnt_q : in_cnt_q + 1'b1;
        if (in_cnt_d == AlarmMax && !StickyAlarm) begin
          alarm_low_d  = 1'b0;
          alarm_high_d = 1'b0;
        end
      end
    end

    if (clear) begin
      for (int i = 0; i < AVG_DEPTH; i++) samp_d[i] = '0;
      wr_ptr_d     = '0;
      fill_d       = '0;
      sum_d        = '0;
      zero_cnt_d   = '0;
      low_cnt_d    = '0;
      high_cnt_d   = '0;
      in_cnt_d     = '0;
      alarm_low_d  = 1'b0;
      alarm_high_d = 1'b0;
      avg_bpm_d    = '0;
      avg_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      for (int i = 0; i < AVG_DEPTH; i++) samp_q[i] <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
      zero_cnt_q   <= '0;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      in_cnt_q     <= '0;
      alarm_low_q  <= 1'b0;
      alarm_high_q <= 1'b0;
      avg_bpm_q    <= '0;
      avg_valid_q  <= 1'b0;
      hb_reset_q   <= 1'b1;
      no_pulse_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      sum_q        <= sum_d;
      zero_cnt_q   <= zero_cnt_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      in_cnt_q     <= in_cnt_d;
      alarm_low_q  <= alarm_low_d;
      alarm_high_q <= alarm_high_d;
      avg_bpm_q    <= avg_bpm_d;
      avg_valid_q  <= avg_valid_d;
      hb_reset_q   <= (state_d == StIdle) || (state_d == StFault);
      no_pulse_q   <= (state_d == StFault);
      busy_q       <= (state_d == StWarmup) || (state_d == StRun);
    end
  end

  assign state      = state_q;
  assign hb_reset   = hb_reset_q;
  assign avg_bpm    = avg_bpm_q;
  assign avg_valid  = avg_valid_q;
  assign alarm_low  = alarm_low_q;
  assign alarm_high = alarm_high_q;
  assign no_pulse   = no_pulse_q;
  assign busy       = busy_q;

endmodule

// File: doc/heartbeat_ctrl.md
# heartbeat_ctrl

- Sequencing controller for the `heartbeat_counter` datapath. It holds the counter in reset while idle and releases it on `start`.
- Discards the first (settling) measurement window, then keeps a sliding average of valid BPM results.
- Raises brady/tachy alarms with hysteresis and declares a no-pulse fault after consecutive zero-BPM windows.
- Sits between the counter and the display/host logic: the counter's `bpm`/`new_bpm` feed in, and the counter's `reset` is driven by `hb_reset`.

## Interface
Parameters:
- `AVG_DEPTH`, 4: samples in sliding average; must be a power of 2, 2..16.
- `LOW_BPM`, 50: a sample strictly below this, and nonzero, is "low".
- `HIGH_BPM`, 120: a sample strictly above this is "high".
- `ALARM_WINDOWS`, 2: consecutive out-of-range samples that set an alarm; the same count of consecutive in-range samples clears it.
- `TIMEOUT_WINDOWS`, 3: consecutive zero-BPM samples that enter FAULT.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin monitoring (level sampled each cycle).
- `stop` in 1: abort to IDLE; priority over everything except `reset`.
- `hb_bpm` in 8: counter result.
- `hb_new_bpm` in 1: counter result strobe, one cycle.
- `hb_reset` out 1: drives counter `reset`.
- `avg_bpm` out 8: sliding average.
- `avg_valid` out 1: one-cycle strobe on each `avg_bpm` update.
- `alarm_low` out 1: bradycardia alarm.
- `alarm_high` out 1: tachycardia alarm.
- `no_pulse` out 1: high in FAULT.
- `busy` out 1: state is WARMUP or RUN.
- `state` out 2: IDLE=0, WARMUP=1, RUN=2, FAULT=3.

## Operation
States:
- IDLE:
  - `hb_reset`=1.
  - `start` → WARMUP.
- WARMUP:
  - `hb_reset`=0.
  - First `hb_new_bpm` is discarded → RUN.
- RUN:
  - Each `hb_new_bpm` is classified:
    - zero: `zero_cnt`++, not averaged; alarm counters untouched.
    - low/high/in-range: `zero_cnt`←0, sample pushed to average.
  - `zero_cnt` reaching `TIMEOUT_WINDOWS` → FAULT.
- FAULT:
  - `hb_reset`=1, `no_pulse`=1.
  - `start` → WARMUP with full clear.
- `stop` in any state → IDLE. Leaving for IDLE, or entering WARMUP, clears:
  - sample buffer, fill count, sum, `zero_cnt`;
  - alarm counters and alarms;
  - `avg_bpm`; `avg_valid` is not asserted.
- `start` in WARMUP/RUN is ignored.

Average:
- Circular buffer of `AVG_DEPTH` × 8 bits, with a running sum of 8+log2(`AVG_DEPTH`) bits.
- Per push: sum ← sum − oldest + new.
- `avg_bpm` = sum >> log2(`AVG_DEPTH`), truncating.
- `avg_valid` pulses only once the buffer has filled, i.e. on the `AVG_DEPTH`-th push and every push after. No strobe before that; `avg_bpm` stays 0.

Alarms, per nonzero sample:
- `out_cnt` tracks consecutive low samples (for `alarm_low`) or high samples (for `alarm_high`), saturating at `ALARM_WINDOWS`.
- An in-range sample resets both `out_cnt`s and increments `in_cnt`.
- Reaching `ALARM_WINDOWS` sets the alarm.
- `in_cnt` reaching `ALARM_WINDOWS` clears both alarms.
- A low sample resets the high counter, and vice versa. `alarm_low` and `alarm_high` are never both 1; setting one clears the other.

## Timing
- Outputs after `reset`:
  - `hb_reset`=1, `state`=IDLE.
  - All other outputs 0: `avg_bpm`, `avg_valid`, both alarms, `no_pulse`, `busy`.
- `start` sampled high in IDLE at edge N:
  - `state`=WARMUP and `hb_reset`=0 after edge N+1.
  - All outputs are registered.
- Accepted `hb_new_bpm` at edge N: `avg_bpm`/`avg_valid`, alarms and the `state` change are visible after edge N+1 (one cycle latency).
- `stop` and `hb_new_bpm` in the same cycle: stop wins, sample dropped.
- `start` and `stop` in the same cycle: stop wins.
- Zero sample completing the timeout: FAULT and `no_pulse` appear after N+1, with no `avg_valid` in that cycle.
- Assertion of `reset` mid-RUN returns to reset values on the next edge.
- `hb_new_bpm` in IDLE/FAULT is ignored.

## Configuration
- `HEARTBEAT_CTRL_STICKY_ALARM_EN`:
  - Defined: alarms latch once set. In-range samples do not clear them; only `stop`, `reset`, or re-entry to WARMUP clear them. A low alarm setting does not clear a latched high alarm, so both may be 1.
  - Undefined: hysteresis clearing as in Operation.

## Test plan
- Reset then `start`, feed `hb_bpm`=72 ×5 strobes (`AVG_DEPTH`=4) → first strobe dropped. `avg_valid` exactly once, after the 5th strobe, with `avg_bpm`=72. No alarms.
- RUN with buffer [60,60,60,60], feed 90, 90 → `avg_bpm`=67 then 75, truncated.
- Feed 40, 40 → `alarm_low`=1 after the 2nd. Then 70 → still 1. Then 70 → 0. Repeat with 130 ×2 → `alarm_high`=1, `alarm_low`=0.
- Feed 0,0,0 in RUN → after the 3rd, `state`=3, `no_pulse`=1, `hb_reset`=1. `start` → `state`=1, `no_pulse`=0, `avg_bpm`=0.
- `stop` coincident with `hb_new_bpm`=80 in RUN → IDLE next cycle, `avg_valid` stays 0, `hb_reset`=1. `start`+`stop` together → stays IDLE.
- With `HEARTBEAT_CTRL_STICKY_ALARM_EN`: 130,130 then 70 ×4 → `alarm_high` remains 1 until `stop`.
